fft_frame_loader: RTL and testbench

Parametrised front-end that captures a frame of streaming ADC samples into the FFT core's banked input RAM and launches the transform. It sits between the ADC sample strobe and `fft_top`. It drives the per-bank write ports (`iADDR_WR_k`/`iWE_k`/`iDATA`), pulses `iSTART`, and waits for `oRDY`. It generalises the fixed 4×512 bank-major load to any bank count and depth, adds an interleaved fill mode and single/continuous capture, and has no backpressure on the ADC.

---
 rtl/fft_frame_loader_if.sv | 27 ++
 rtl/fft_frame_loader.sv | 142 ++++++++++++++
 tb/tb_fft_frame_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_loader_if.sv
// Sample-stream and banked-RAM write bus between ADC, frame loader and fft_top.
// The loader uses the master modport; the environment side uses slave.
interface fft_frame_loader_if #(
    parameter int DATA_W = 16,
    parameter int BANKS  = 4,
    parameter int DEPTH  = 512
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]        iDATA;
    logic                     iVALID;
    logic                     iRDY;
    logic [DATA_W-1:0]        oDATA;
    logic [BANKS*ADDR_W-1:0]  oADDR_WR;
    logic [BANKS-1:0]         oWE;
    logic                     oSTART;

    modport master (
        input  iDATA, iVALID, iRDY,
        output oDATA, oADDR_WR, oWE, oSTART
    );

    modport slave (
        output iDATA, iVALID, iRDY,
        input  oDATA, oADDR_WR, oWE, oSTART
    );
endinterface

// File: rtl/fft_frame_loader.sv
// Captures one frame of ADC samples into banked FFT input RAM, then launches the FFT.
// Optional dropped-sample counter: define FFT_LOADER_OVF_CNT_EN.
module fft_frame_loader #(
    parameter int DATA_W     = 16,
    parameter int BANKS      = 4,
    parameter int DEPTH      = 512,
    parameter int INTERLEAVE = 0
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iARM,
    input  logic                 iCONT,
    input  logic                 iABORT,
    output logic                 oBUSY,
    output logic [15:0]          oOVF_CNT,
    fft_frame_loader_if.master   bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int N      = BANKS * DEPTH;
    localparam int CNT_W  = $clog2(N);
    localparam int BANK_W = $clog2(BANKS);

    typedef enum logic [1:0] {
        S_IDLE, S_FILL, S_LAUNCH, S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [BANKS-1:0]    we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                start_q, start_d;
    logic                rdy_q;

    logic [BANK_W-1:0]   bank;
    logic [ADDR_W-1:0]   addr;
    logic                rdy_edge;
    logic                last;

    generate
        if (INTERLEAVE == 0) begin : g_bank_major
            assign bank = n_q[CNT_W-1:ADDR_W];
            assign addr = n_q[ADDR_W-1:0];
        end else begin : g_round_robin
            assign bank = n_q[BANK_W-1:0];
            assign addr = n_q[CNT_W-1:BANK_W];
        end
    endgenerate

    // Only a fresh 0->1 of oRDY ends WAIT; a level left over is ignored.
    assign rdy_edge = bus.iRDY & ~rdy_q;
    assign last     = (n_q == CNT_W'(N - 1));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        we_d    = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        start_d = 1'b0;
        if (iABORT) begin
            state_d = S_IDLE;
            n_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (iARM) begin
                        state_d = S_FILL;
                        n_d     = '0;
                    end
                end
                S_FILL: begin
                    if (bus.iVALID) begin
                        we_d   = BANKS'(1) << bank;
                        addr_d = addr;
                        data_d = bus.iDATA;
                        n_d    = n_q + CNT_W'(1);
                        if (last) state_d = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (rdy_edge) begin
                        state_d = iCONT ? S_FILL : S_IDLE;
                        n_d     = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            start_q <= start_d;
            rdy_q   <= bus.iRDY;
        end
    end

    assign bus.oDATA    = data_q;
    assign bus.oADDR_WR = {BANKS{addr_q}};
    assign bus.oWE      = we_q;
    assign bus.oSTART   = start_q;
    assign oBUSY        = (state_q != S_IDLE);

`ifdef FFT_LOADER_OVF_CNT_EN
    logic [15:0] ovf_q, ovf_d;
    logic        drop;

    assign drop = bus.iVALID && (state_q != S_FILL);

    always_comb begin
        ovf_d = ovf_q;
        if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) ovf_q <= '0;
        else         ovf_q <= ovf_d;
    end

    assign oOVF_CNT = ovf_q;
`else
    assign oOVF_CNT = '0;
`endif
endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench: bank-major 4x512 loader (u0) and interleaved 4x8 loader (u1).
module tb_fft_frame_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arm0 = 0, cont0 = 0, abort0 = 0, busy0;
    logic arm1 = 0, cont1 = 0, abort1 = 0, busy1;
    logic [15:0] ovf0, ovf1;
    int checks = 0;
    int errors = 0;

`ifdef FFT_LOADER_OVF_CNT_EN
    localparam int OVF_EXP = 5;
`else
    localparam int OVF_EXP = 0;
`endif

    fft_frame_loader_if #(.DATA_W(16), .BANKS(4), .DEPTH(512)) b0 ();
    fft_frame_loader_if #(.DATA_W(16), .BANKS(4), .DEPTH(8))   b1 ();

    fft_frame_loader #(.DATA_W(16), .BANKS(4), .DEPTH(512), .INTERLEAVE(0)) u0 (
        .iCLK(clk), .iRESET(rst_n), .iARM(arm0), .iCONT(cont0),
        .iABORT(abort0), .oBUSY(busy0), .oOVF_CNT(ovf0), .bus(b0)
    );

    fft_frame_loader #(.DATA_W(16), .BANKS(4), .DEPTH(8), .INTERLEAVE(1)) u1 (
        .iCLK(clk), .iRESET(rst_n), .iARM(arm1), .iCONT(cont1),
        .iABORT(abort1), .oBUSY(busy1), .oOVF_CNT(ovf1), .bus(b1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        b0.iDATA = 0; b0.iVALID = 0; b0.iRDY = 0;
        b1.iDATA = 0; b1.iVALID = 0; b1.iRDY = 0;
        tick();
        checks++;
        if (b0.oWE !== 4'b0 || b0.oSTART !== 1'b0) begin
            errors++; $display("FAIL reset_we_start got %b %b want 0 0", b0.oWE, b0.oSTART);
        end
        checks++;
        if (b0.oADDR_WR !== 36'h0 || b0.oDATA !== 16'h0) begin
            errors++; $display("FAIL reset_addr_data got %h %h want 0 0", b0.oADDR_WR, b0.oDATA);
        end
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b %b want 0 0", busy0, busy1);
        end
        checks++;
        if (ovf0 !== 16'h0 || ovf1 !== 16'h0) begin
            errors++; $display("FAIL reset_ovf got %0d %0d want 0 0", ovf0, ovf1);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bank_major;
        int bad = 0;
        int first = -1;
        arm0 = 1; tick(); arm0 = 0;
        checks++;
        if (busy0 !== 1'b1) begin
            errors++; $display("FAIL bm_busy_rise got %b want 1", busy0);
        end
        for (int n = 0; n < 2048; n++) begin
            b0.iVALID = 1; b0.iDATA = 16'(n);
            tick();
            if (b0.oWE !== 4'(1 << (n / 512)) || b0.oADDR_WR !== {4{9'(n % 512)}} ||
                b0.oDATA !== 16'(n) || b0.oSTART !== 1'b0) begin
                bad++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bm_writes got %0d bad (first n=%0d) want 0", bad, first);
        end
        b0.iVALID = 0;
        tick();
        checks++;
        if (b0.oWE !== 4'b0 || b0.oSTART !== 1'b1) begin
            errors++; $display("FAIL bm_launch got we=%b start=%b want 0 1", b0.oWE, b0.oSTART);
        end
        tick();
        checks++;
        if (b0.oSTART !== 1'b0 || busy0 !== 1'b1) begin
            errors++; $display("FAIL bm_wait got start=%b busy=%b want 0 1", b0.oSTART, busy0);
        end
        b0.iRDY = 1; tick();
        checks++;
        if (busy0 !== 1'b0) begin
            errors++; $display("FAIL bm_done got busy=%b want 0", busy0);
        end
    endtask

    task automatic test_interleave;
        int bad = 0;
        int first = -1;
        b1.iRDY = 1;
        arm1 = 1; tick(); arm1 = 0;
        for (int n = 0; n < 32; n++) begin
            b1.iVALID = 1; b1.iDATA = 16'(n);
            tick();
            if (b1.oWE !== 4'(1 << (n % 4)) || b1.oADDR_WR !== {4{3'(n / 4)}} ||
                b1.oDATA !== 16'(n)) begin
                bad++;
                if (first < 0) first = n;
            end
            if (n == 5) begin
                checks++;
                if (b1.oWE !== 4'b0010 || b1.oADDR_WR !== 12'o1111) begin
                    errors++; $display("FAIL il_sample5 got we=%b addr=%o want 0010 1111", b1.oWE, b1.oADDR_WR);
                end
            end
            if (n == 31) begin
                checks++;
                if (b1.oWE !== 4'b1000 || b1.oADDR_WR !== 12'o7777) begin
                    errors++; $display("FAIL il_sample31 got we=%b addr=%o want 1000 7777", b1.oWE, b1.oADDR_WR);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL il_writes got %0d bad (first n=%0d) want 0", bad, first);
        end
        b1.iVALID = 0;
        tick();
        checks++;
        if (b1.oSTART !== 1'b1 || b1.oWE !== 4'b0) begin
            errors++; $display("FAIL il_launch got start=%b we=%b want 1 0", b1.oSTART, b1.oWE);
        end
        tick();
    endtask

    task automatic test_wait_edge;
        int early = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy1 !== 1'b1) early++;
        end
        b1.iRDY = 0; tick();
        if (busy1 !== 1'b1) early++;
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL wait_level got %0d early exits want 0", early);
        end
        cont1 = 1; b1.iRDY = 1; tick();
        checks++;
        if (busy1 !== 1'b1 || b1.oWE !== 4'b0) begin
            errors++; $display("FAIL wait_cont got busy=%b we=%b want 1 0", busy1, b1.oWE);
        end
        b1.iVALID = 1; b1.iDATA = 16'd77; tick();
        checks++;
        if (b1.oWE !== 4'b0001 || b1.oADDR_WR !== 12'h0 || b1.oDATA !== 16'd77) begin
            errors++; $display("FAIL wait_next_frame got we=%b addr=%h data=%0d want 0001 0 77",
                               b1.oWE, b1.oADDR_WR, b1.oDATA);
        end
        b1.iVALID = 0; cont1 = 0; abort1 = 1; tick(); abort1 = 0;
        checks++;
        if (busy1 !== 1'b0) begin
            errors++; $display("FAIL wait_abort got busy=%b want 0", busy1);
        end
    endtask

    task automatic test_abort;
        int starts = 0;
        arm0 = 1; tick(); arm0 = 0;
        for (int n = 0; n < 100; n++) begin
            b0.iVALID = 1; b0.iDATA = 16'(n); tick();
        end
        abort0 = 1; arm0 = 1; b0.iDATA = 16'd999; tick();
        abort0 = 0; arm0 = 0; b0.iVALID = 0;
        checks++;
        if (busy0 !== 1'b0 || b0.oWE !== 4'b0 || b0.oSTART !== 1'b0) begin
            errors++; $display("FAIL abort_now got busy=%b we=%b start=%b want 0 0 0",
                               busy0, b0.oWE, b0.oSTART);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (b0.oSTART !== 1'b0 || busy0 !== 1'b0) starts++;
        end
        checks++;
        if (starts != 0) begin
            errors++; $display("FAIL abort_quiet got %0d bad cycles want 0", starts);
        end
        arm0 = 1; tick(); arm0 = 0;
        b0.iVALID = 1; b0.iDATA = 16'h55; tick(); b0.iVALID = 0;
        checks++;
        if (b0.oWE !== 4'b0001 || b0.oADDR_WR !== 36'h0 || b0.oDATA !== 16'h55) begin
            errors++; $display("FAIL abort_rearm got we=%b addr=%h data=%h want 0001 0 55",
                               b0.oWE, b0.oADDR_WR, b0.oDATA);
        end
        abort0 = 1; tick(); abort0 = 0;
    endtask

    task automatic test_ovf;
        checks++;
        if (ovf1 !== 16'd0) begin
            errors++; $display("FAIL ovf_start got %0d want 0", ovf1);
        end
        b1.iVALID = 1;
        for (int i = 0; i < 3; i++) tick();
        b1.iVALID = 0;
        arm1 = 1; tick(); arm1 = 0;
        for (int n = 0; n < 32; n++) begin
            b1.iVALID = 1; b1.iDATA = 16'(n); tick();
        end
        b1.iVALID = 0;
        tick(); tick();
        b1.iVALID = 1; tick(); tick(); b1.iVALID = 0;
        tick();
        checks++;
        if (ovf1 !== 16'(OVF_EXP)) begin
            errors++; $display("FAIL ovf_count got %0d want %0d", ovf1, OVF_EXP);
        end
        checks++;
        if (ovf0 !== 16'd0) begin
            errors++; $display("FAIL ovf_other got %0d want 0", ovf0);
        end
        b1.iRDY = 0; tick(); b1.iRDY = 1; tick();
        checks++;
        if (busy1 !== 1'b0) begin
            errors++; $display("FAIL ovf_exit got busy=%b want 0", busy1);
        end
    endtask

    task automatic test_async_reset;
        int bad = 0;
        arm0 = 1; tick(); arm0 = 0;
        for (int n = 0; n < 3; n++) begin
            b0.iVALID = 1; b0.iDATA = 16'(n + 40); tick();
        end
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (b0.oWE !== 4'b0 || b0.oADDR_WR !== 36'h0 || b0.oDATA !== 16'h0 ||
            b0.oSTART !== 1'b0 || busy0 !== 1'b0) begin
            errors++; $display("FAIL async_reset got we=%b addr=%h data=%h start=%b busy=%b want all 0",
                               b0.oWE, b0.oADDR_WR, b0.oDATA, b0.oSTART, busy0);
        end
        b0.iVALID = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy0 !== 1'b0 || b0.oSTART !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL async_idle got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_bank_major();
        test_interleave();
        test_wait_edge();
        test_abort();
        test_ovf();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
